truth_table_sequencer: RTL and testbench
========================================

// Module: truth_table_sequencer
// PURPOSE
//   Sequences a small combinational gate-level DUT through every input combination.
//   For each vector it drives the DUT inputs, waits a settle window that covers gate
//   propagation delay, then samples the DUT output against an expected truth table.
//   It reports the captured table, a mismatch count and the first failing vector.
//   Sits beside the 3-input lab circuits as their on-board self-check controller.
// PARAMETERS
//   N_IN          3      DUT input count; vectors 0 .. 2**N_IN-1, index = {a,b,c} MSB-first
//   SETTLE_CYCLES 4      clocks between driving a vector and sampling; legal range >= 1
//   EXP_TABLE     8'hE0  expected output per vector; bit i = f for vector i (f = ab + ac)
// PORTS
//   clk             input   1          system clock, rising edge
//   rst_n           input   1          synchronous reset, active low
//   start           input   1          run request; sampled only in IDLE or DONE
//   dut_out         input   1          DUT output f
//   dut_in          output  N_IN       registered DUT inputs {a,b,c}
//   busy            output  1          high from APPLY of vector 0 through last SAMPLE
//   done            output  1          high in DONE, held until next start or reset
//   pass            output  1          done && (err_count == 0)
//   err_count       output  N_IN+1     number of mismatching vectors, 0 .. 2**N_IN
//   first_fail_idx  output  N_IN       lowest failing vector index, valid when fail_seen
//   fail_seen       output  1          at least one mismatch in the current run
//   capture         output  2**N_IN    sampled dut_out; bit i = vector i
// BEHAVIOUR
//   Clocking: one clock (clk); reset is synchronous and active-low (rst_n).
//   Reset (rst_n=0 at a rising edge): state=IDLE; dut_in, err_count, first_fail_idx,
//     capture = 0; busy, done, pass, fail_seen = 0. Applies mid-run; run abandoned.
//   FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
//   IDLE: start=1 -> APPLY; idx=0; clear err_count, fail_seen, first_fail_idx, capture.
//   APPLY (1 cycle): dut_in<=idx; settle counter<=SETTLE_CYCLES-1; -> SETTLE.
//   SETTLE: counter==0 -> SAMPLE, else decrement; dut_in stable throughout.
//   SAMPLE (1 cycle): capture[idx]<=dut_out; mismatch = (dut_out !== EXP_TABLE[idx]),
//     so X/Z on dut_out counts as a mismatch. On mismatch: err_count+1; if !fail_seen
//     then first_fail_idx<=idx, fail_seen<=1. idx==2**N_IN-1 -> DONE, else idx+1 -> APPLY.
//   DONE: done=1, busy=0, dut_in holds last vector; start=1 -> same as IDLE start.
//   Timing: start seen at edge t -> vector 0 APPLY at t+1; per vector SETTLE_CYCLES+2
//     cycles; done first high at t+1+2**N_IN*(SETTLE_CYCLES+2) (t+49 with defaults).
//   start while busy is ignored; start and rst_n=0 together -> reset wins.
//   err_count is N_IN+1 bits so all-vectors-fail (8) never wraps; idx wraps never occur
//     because SAMPLE of the last index exits to DONE.
//   capture, err_count, fail_seen, first_fail_idx hold in DONE until next start/reset.
//   Settle rule: SETTLE_CYCLES*T_clk must exceed DUT worst-case path (2 levels x 10ns).
// TESTING
//   1 Reset: rst_n=0 for 2 clocks -> all outputs 0, state IDLE, busy=0, done=0.
//   2 Good DUT (f=ab+ac, 10ns gates, 10ns clk): start pulse -> done at t+49, pass=1,
//     err_count=0, fail_seen=0, capture=8'hE0, dut_in stepped 0..7 in order.
//   3 Faulty DUT f=a&b: run -> capture=8'hC0, err_count=1, first_fail_idx=5, pass=0.
//   4 Stuck-at-1 DUT: run -> capture=8'hFF, err_count=5, first_fail_idx=0, fail_seen=1.
//   5 start pulsed at vector 3 SETTLE -> ignored, timing unchanged; start in DONE ->
//     counters cleared next cycle, full second run reproduces scenario 2 results.
//   6 rst_n=0 during vector 4 SAMPLE -> next edge all outputs 0, no capture update,
//     IDLE; subsequent start runs cleanly to done with pass=1.

Source files
------------

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - steps a small combinational DUT through every input vector and checks it
module truth_table_sequencer #(
  parameter int                 N_IN          = 3,
  parameter int                 SETTLE_CYCLES = 4,
  parameter logic [2**N_IN-1:0] EXP_TABLE     = 8'hE0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      dut_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      first_fail_idx,
  output logic                 fail_seen,
  output logic [2**N_IN-1:0]   capture
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [CW-1:0]   cnt;
  logic            exp_bit;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  // X/Z on the DUT output must never be taken as a match.
  always_comb begin
    exp_bit  = EXP_TABLE[idx];
    mismatch = (dut_out !== exp_bit);
    err_next = err_count + {{N_IN{1'b0}}, mismatch};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      cnt            <= '0;
      dut_in         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_idx <= '0;
      fail_seen      <= 1'b0;
      capture        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= APPLY;
            idx            <= '0;
            err_count      <= '0;
            fail_seen      <= 1'b0;
            first_fail_idx <= '0;
            capture        <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
          end
        end
        APPLY: begin
          dut_in <= idx;
          cnt    <= CW'(SETTLE_CYCLES - 1);
          state  <= SETTLE;
        end
        SETTLE: begin
          if (cnt == '0) state <= SAMPLE;
          else           cnt   <= cnt - 1'b1;
        end
        SAMPLE: begin
          capture[idx] <= dut_out;
          err_count    <= err_next;
          if (mismatch && !fail_seen) begin
            first_fail_idx <= idx;
            fail_seen      <= 1'b1;
          end
          // Leaving from the last index means idx never has to wrap.
          if (idx == {N_IN{1'b1}}) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            idx   <= idx + 1'b1;
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb/tb_truth_table_sequencer.sv - self-checking bench for truth_table_sequencer
module tb_truth_table_sequencer;

  localparam int NV  = 8;
  localparam int SET = 4;
  localparam int PER = SET + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dut_out = 1'b0;
  logic [2:0] dut_in;
  logic       busy, done, pass, fail_seen;
  logic [3:0] err_count;
  logic [2:0] first_fail_idx;
  logic [7:0] capture;

  logic [7:0] exp_tab = 8'hE0;
  int mode = 0;  // 0: f=ab+ac, 1: f=ab, 2: stuck-at-1
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  truth_table_sequencer #(.N_IN(3), .SETTLE_CYCLES(SET), .EXP_TABLE(8'hE0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out),
    .dut_in(dut_in), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_idx(first_fail_idx),
    .fail_seen(fail_seen), .capture(capture)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic f_of(input int m, input int v);
    logic a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    case (m)
      0:       return (a & b) | (a & c);
      1:       return a & b;
      default: return 1'b1;
    endcase
  endfunction

  // Two gate levels of 10ns each.
  always @(dut_in or mode) begin
    #20;
    dut_out = f_of(mode, int'(dut_in));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: k counts edges since the accepted start edge; vector v is applied at
  // edge v*PER+1 and sampled at edge (v+1)*PER.
  bit         m_run, m_done, m_fs, chk_en;
  int         k, m_err, m_ffi, m_din;
  logic [7:0] m_cap;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_fs = 0; m_err = 0; m_ffi = 0; m_din = 0; m_cap = '0;
      chk_en = 1;
    end else if (start && !m_run) begin
      m_run = 1; k = 0; m_done = 0; m_fs = 0; m_err = 0; m_ffi = 0; m_cap = '0;
    end else if (m_run) begin
      k++;
      if (k % PER == 1) m_din = (k - 1) / PER;
      if (k % PER == 0) begin
        int   v;
        logic b;
        v = k / PER - 1;
        b = f_of(mode, v);
        m_cap[v] = b;
        if (b !== exp_tab[v]) begin
          m_err++;
          if (!m_fs) begin m_fs = 1; m_ffi = v; end
        end
      end
      if (k == PER * NV) begin m_run = 0; m_done = 1; end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_run);
      check("done", done, m_done);
      check("pass", pass, m_done && m_err == 0);
      check("err_count", err_count, m_err);
      check("fail_seen", fail_seen, m_fs);
      check("first_fail_idx", first_fail_idx, m_ffi);
      check("capture", capture, m_cap);
      check("dut_in", dut_in, m_din);
    end
  end

  task automatic do_start(output int t);
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    t = cyc;
  endtask

  // lat = number of edges after the start edge until an edge samples done high.
  task automatic wait_done(input int t);
    int lat;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin lat = cyc + 1 - t; break; end
    end
    check("done_latency", lat, 49);
    #3;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_fs"}, fail_seen, 0);
    check({tag, "_ffi"}, first_fail_idx, 0);
    check({tag, "_cap"}, capture, 0);
    check({tag, "_din"}, dut_in, 0);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 check_all_zero("reset");
    rst_n = 1'b1;

    mode = 0;
    do_start(t);
    wait_done(t);
    check("good_cap", capture, 8'hE0);
    check("good_err", err_count, 0);
    check("good_pass", pass, 1);
    check("good_fs", fail_seen, 0);
    check("good_din", dut_in, 7);

    mode = 1;
    do_start(t);
    wait_done(t);
    check("and_cap", capture, 8'hC0);
    check("and_err", err_count, 1);
    check("and_ffi", first_fail_idx, 5);
    check("and_pass", pass, 0);

    mode = 2;
    do_start(t);
    wait_done(t);
    check("sa1_cap", capture, 8'hFF);
    check("sa1_err", err_count, 5);
    check("sa1_ffi", first_fail_idx, 0);
    check("sa1_fs", fail_seen, 1);

    mode = 0;
    do_start(t);
    check("restart_err", err_count, 0);
    check("restart_cap", capture, 0);
    check("restart_fs", fail_seen, 0);
    check("restart_done", done, 0);
    check("restart_busy", busy, 1);
    while (cyc < t + 20) begin @(posedge clk); #2; end
    start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_done(t);
    check("ignored_start_cap", capture, 8'hE0);
    check("ignored_start_pass", pass, 1);
    do_start(t);
    wait_done(t);
    check("rerun_cap", capture, 8'hE0);
    check("rerun_pass", pass, 1);
    check("rerun_err", err_count, 0);

    do_start(t);
    while (cyc < t + 29) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    @(posedge clk); #2;
    check_all_zero("midrst");
    rst_n = 1'b1;
    do_start(t);
    wait_done(t);
    check("post_rst_cap", capture, 8'hE0);
    check("post_rst_pass", pass, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
